rsa_modinv_engine: RTL and testbench

- Parametrised, fully sequential modular-inverse engine: computes d = a^-1 mod m using the extended Euclidean algorithm.
- Built from an iterative shift-subtract divider and a shift-add multiplier.
- Serves as the private-exponent stage of the RSA key-generation datapath (a = e, m = phi).
- Successor to the single-cycle inverse: width is parametrised, it uses a valid/ready handshake and reports a non-invertible error.
- The secret result is visible only on res_d while res_valid is high; it is zeroised after handoff. There is no debug or secret-exposure port.

---
 rtl/rsa_modinv_engine.sv | 158 +++++++++++++++
 tb/tb_rsa_modinv_engine.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modinv_engine.sv
// Sequential modular inverse d = a^-1 mod m via the extended Euclidean algorithm,
// built from a restoring shift-subtract divider and a shift-add multiplier.
module rsa_modinv_engine #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_m,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_d,
  output logic             res_err,
  output logic             busy
);

  localparam int TW = WIDTH + 2;

  typedef enum logic [2:0] {IDLE, CHECK, DIV, MUL, UPD, FINISH, HOLD} state_t;

  state_t            state;
  logic [WIDTH-1:0]  r0, r1, q, rem, m_val;
  logic [TW-1:0]     t0, t1, prod;
  logic [CNT_W-1:0]  cnt;
  logic              err_flag;

  logic [WIDTH:0]    trial;
  logic              trial_ge;
  logic [WIDTH-1:0]  trial_sub;
  logic [TW-1:0]     prod_step;
  logic [WIDTH-1:0]  t0_wrap;
  logic              last_step;
  logic              bad_operands;

  // q doubles as the dividend shift register: its MSB feeds the partial remainder.
  assign trial        = {rem, q[WIDTH-1]};
  assign trial_ge     = trial >= {1'b0, r1};
  assign trial_sub    = trial[WIDTH-1:0] - r1;
  assign prod_step    = {prod[TW-2:0], 1'b0} + (q[WIDTH-1] ? t1 : '0);
  assign t0_wrap      = t0[WIDTH-1:0] + m_val;
  assign last_step    = cnt == CNT_W'(WIDTH - 1);
  assign bad_operands = (m_val < WIDTH'(2)) || (r1 == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      res_valid <= 1'b0;
      res_d     <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
      r0        <= '0;
      r1        <= '0;
      q         <= '0;
      rem       <= '0;
      m_val     <= '0;
      t0        <= '0;
      t1        <= '0;
      prod      <= '0;
      cnt       <= '0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r0        <= req_m;
            r1        <= req_a;
            m_val     <= req_m;
            t0        <= '0;
            t1        <= TW'(1);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          err_flag <= bad_operands;
          if (bad_operands) begin
            state <= FINISH;
          end else begin
            q     <= r0;
            rem   <= '0;
            cnt   <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          q   <= {q[WIDTH-2:0], trial_ge};
          rem <= trial_ge ? trial_sub : trial[WIDTH-1:0];
          cnt <= cnt + CNT_W'(1);
          if (last_step) begin
            cnt   <= '0;
            prod  <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          // MSB-first shift-add; truncation to TW bits is exact since |q*t1| <= m.
          prod <= prod_step;
          q    <= {q[WIDTH-2:0], 1'b0};
          cnt  <= cnt + CNT_W'(1);
          if (last_step) begin
            cnt   <= '0;
            state <= UPD;
          end
        end
        UPD: begin
          r0 <= r1;
          r1 <= rem;
          t0 <= t1;
          t1 <= t0 - prod;
          if (rem == '0) begin
            state <= FINISH;
          end else begin
            q     <= r1;
            rem   <= '0;
            state <= DIV;
          end
        end
        FINISH: begin
          res_valid <= 1'b1;
          if (err_flag || (r0 != WIDTH'(1))) begin
            res_err <= 1'b1;
            res_d   <= '0;
          end else begin
            res_d <= t0[TW-1] ? t0_wrap : t0[WIDTH-1:0];
          end
          state <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            // Secret material is wiped as soon as the consumer takes the result.
            res_valid <= 1'b0;
            res_d     <= '0;
            res_err   <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            r0        <= '0;
            r1        <= '0;
            q         <= '0;
            rem       <= '0;
            m_val     <= '0;
            t0        <= '0;
            t1        <= '0;
            prod      <= '0;
            err_flag  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modinv_engine.sv
// Scoreboard bench for rsa_modinv_engine: a WIDTH=16 instance for directed vectors
// and a WIDTH=1024 instance for the RSA-sized inverse.
module tb_rsa_modinv_engine;

  localparam int W  = 16;
  localparam int WB = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst16_n, rst1k_n;
  logic          req_valid, req_ready, res_valid, res_ready, res_err, busy;
  logic [W-1:0]  req_a, req_m, res_d;
  logic          bk_req_valid, bk_req_ready, bk_res_valid, bk_res_ready, bk_res_err, bk_busy;
  logic [WB-1:0] bk_req_a, bk_req_m, bk_res_d;

  rsa_modinv_engine #(.WIDTH(W)) dut16 (
    .clk(clk), .rst_n(rst16_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_m(req_m),
    .res_valid(res_valid), .res_ready(res_ready), .res_d(res_d), .res_err(res_err),
    .busy(busy)
  );

  rsa_modinv_engine #(.WIDTH(WB)) dut1k (
    .clk(clk), .rst_n(rst1k_n),
    .req_valid(bk_req_valid), .req_ready(bk_req_ready), .req_a(bk_req_a), .req_m(bk_req_m),
    .res_valid(bk_res_valid), .res_ready(bk_res_ready), .res_d(bk_res_d), .res_err(bk_res_err),
    .busy(bk_busy)
  );

  typedef struct {
    longint unsigned a;
    longint unsigned m;
    longint unsigned d;
    logic            err;
    int              lat;
    string           name;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  int cyc = 0, acc_edge = 0, bk_acc_edge = 0, bk_acc_cnt = 0;

  // Edge index of the most recent accept; latency counts the accept edge as cycle 1.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) acc_edge <= cyc + 1;
    if (bk_req_valid && bk_req_ready) begin
      bk_acc_edge <= cyc + 1;
      bk_acc_cnt  <= bk_acc_cnt + 1;
    end
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: compares the first cycle of each presented result against the queue head.
  initial begin
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (res_valid && !seen) begin
        seen = 1'b1;
        if (sbq.size() == 0) begin
          timeout("unexpected_result");
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_d"}, 64'(res_d), e.d);
          chk({e.name, "_err"}, 64'(res_err), 64'(e.err));
          chk({e.name, "_lat"}, 64'(cyc - acc_edge + 1), 64'(e.lat));
          if (!e.err) chk({e.name, "_inv"}, (e.a * 64'(res_d)) % e.m, 64'd1);
          $display("txn %s: a=%0d m=%0d d=%0d err=%0d lat=%0d",
                   e.name, e.a, e.m, res_d, res_err, cyc - acc_edge + 1);
        end
      end
      if (!res_valid) seen = 1'b0;
    end
  end

  task automatic send(input longint unsigned a, input longint unsigned m, input longint unsigned d,
                      input logic err, input int lat, input string name, input bit push);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) begin
      timeout({name, "_req_ready"});
    end else begin
      if (push) begin
        e.a = a; e.m = m; e.d = d; e.err = err; e.lat = lat; e.name = name;
        sbq.push_back(e);
      end
      req_a     = W'(a);
      req_m     = W'(m);
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_a     = W'($urandom);
      req_m     = W'($urandom);
      chk({name, "_busy"}, 64'(busy), 64'd1);
      chk({name, "_ready_low"}, 64'(req_ready), 64'd0);
    end
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = (sbq.size() == 0) && !res_valid && req_ready;
    end
    if (!done) timeout({name, "_done"});
  endtask

  initial begin
    bit got;
    longint unsigned bk_m, bk_d;

    rst16_n = 1'b0; rst1k_n = 1'b0;
    req_valid = 1'b0; req_a = '0; req_m = '0; res_ready = 1'b1;
    bk_req_valid = 1'b0; bk_req_a = '0; bk_req_m = '0; bk_res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_d", 64'(res_d), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst16_n = 1'b1;
    rst1k_n = 1'b1;

    send(3, 11, 4, 1'b0, 102, "inv3_11", 1'b1);      wait_done("inv3_11");
    send(17, 3120, 2753, 1'b0, 135, "inv17_3120", 1'b1); wait_done("inv17_3120");
    send(6, 9, 0, 1'b1, 69, "gcd3", 1'b1);            wait_done("gcd3");
    send(3, 1, 0, 1'b1, 3, "m_one", 1'b1);            wait_done("m_one");
    send(0, 11, 0, 1'b1, 3, "a_zero", 1'b1);          wait_done("a_zero");

    // Backpressure: result must hold while res_ready is low.
    res_ready = 1'b0;
    send(14, 11, 4, 1'b0, 168, "a_ge_m", 1'b1);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = res_valid;
    end
    if (!got) timeout("hold_wait");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_d", 64'(res_d), 64'd4);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_valid", 64'(res_valid), 64'd0);
    chk("hs_d_zero", 64'(res_d), 64'd0);
    chk("hs_err", 64'(res_err), 64'd0);
    chk("hs_req_ready", 64'(req_ready), 64'd1);
    chk("hs_busy", 64'(busy), 64'd0);

    // Asynchronous abort in the middle of the divider.
    send(17, 3120, 0, 1'b0, 0, "abort", 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst16_n = 1'b0;
    #1;
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_res_d", 64'(res_d), 64'd0);
    chk("abort_res_err", 64'(res_err), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst16_n = 1'b1;
    send(3, 11, 4, 1'b0, 102, "after_abort", 1'b1);
    wait_done("after_abort");

    // RSA-sized instance: e = 65537, phi = 49998 * 54434, req_valid held throughout.
    bk_m = 64'd2721591132;
    @(negedge clk);
    bk_req_a     = WB'(65537);
    bk_req_m     = WB'(bk_m);
    bk_req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40000 && !got; i++) begin
      @(negedge clk);
      got = bk_res_valid;
    end
    if (!got) begin
      timeout("rsa1k_wait");
    end else begin
      bk_d = bk_res_d[63:0];
      chk("rsa1k_err", 64'(bk_res_err), 64'd0);
      chk("rsa1k_upper_zero", 64'(bk_res_d[WB-1:64] == '0), 64'd1);
      chk("rsa1k_in_range", 64'((bk_d != 0) && (bk_d < bk_m)), 64'd1);
      chk("rsa1k_inv", (64'd65537 * bk_d) % bk_m, 64'd1);
      chk("rsa1k_lat", 64'(cyc - bk_acc_edge + 1), 64'd28689);
      $display("txn rsa1k: a=65537 m=%0d d=%0d err=%0d lat=%0d",
               bk_m, bk_d, bk_res_err, cyc - bk_acc_edge + 1);
    end
    bk_res_ready = 1'b1;
    @(posedge clk);
    #1;
    bk_req_valid = 1'b0;
    chk("rsa1k_hs_valid", 64'(bk_res_valid), 64'd0);
    chk("rsa1k_hs_d_zero", 64'(bk_res_d == '0), 64'd1);
    chk("rsa1k_hs_ready", 64'(bk_req_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("rsa1k_accepts", 64'(bk_acc_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
